// File: rtl/mul_seq_if.sv
// Operand/result handshake bundle for mul_seq.
// slave = multiplier side, master = producer/consumer side.
interface mul_seq_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0]   a;
  logic [DATAWIDTH-1:0]   b;
  logic                   in_valid;
  logic                   in_ready;
  logic [2*DATAWIDTH-1:0] prod;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, prod, out_valid
  );

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, prod, out_valid
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add sequential multiplier, one multiplier bit per clock, full 2W product.
// MUL_SEQ_SIGNED_EN: two's-complement operands via sign/magnitude around the unsigned core.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// BUSY  | DATAWIDTH shift-add iterations, last one writes prod
// DONE  | out_valid=1, prod held until out_ready
module mul_seq #(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = $clog2(DATAWIDTH+1)
) (
  input logic      Clk,
  input logic      Rst_n,
  mul_seq_if.slave bus
);
  localparam int PW = 2*DATAWIDTH;
  localparam logic [CNTWIDTH-1:0] LP_LAST = CNTWIDTH'(DATAWIDTH-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               r_state;
  logic [PW-1:0]        r_mcand;
  logic [PW-1:0]        r_acc;
  logic [PW-1:0]        r_prod;
  logic [DATAWIDTH-1:0] r_mplier;
  logic [CNTWIDTH-1:0]  r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [PW-1:0]        w_acc_next;
  logic [PW-1:0]        w_result;
  logic [DATAWIDTH-1:0] w_a_load;
  logic [DATAWIDTH-1:0] w_b_load;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef MUL_SEQ_SIGNED_EN
  logic r_neg;

  // The most-negative value negates to itself, which read unsigned is its exact magnitude.
  assign w_a_load = bus.a[DATAWIDTH-1] ? -bus.a : bus.a;
  assign w_b_load = bus.b[DATAWIDTH-1] ? -bus.b : bus.b;
  assign w_result = r_neg ? -w_acc_next : w_acc_next;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      r_neg <= 1'b0;
    else if (r_state == IDLE && bus.in_valid)
      r_neg <= bus.a[DATAWIDTH-1] ^ bus.b[DATAWIDTH-1];
  end
`else
  assign w_a_load = bus.a;
  assign w_b_load = bus.b;
  assign w_result = w_acc_next;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mcand    <= PW'(w_a_load);
            r_mplier   <= w_b_load;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNTWIDTH'(1);
          if (r_cnt == LP_LAST) begin
            r_prod      <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.prod      = r_prod;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: driver pushes reference products, monitor pops and compares.
// Honours MUL_SEQ_SIGNED_EN for the reference model and the signed directed cases.
module tb_mul_seq;
  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] p;
    int             acc;
  } exp_t;

  logic Clk;
  logic Rst_n;
  mul_seq_if #(.DATAWIDTH(W)) bus ();

  mul_seq #(.DATAWIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   or_mode  = 0;
  bit   seen     = 0;
  bit   pend_ir  = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the exact mathematical product, wrapped into 2W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx;
    int sy;
    sx = int'(x);
    sy = int'(y);
`ifdef MUL_SEQ_SIGNED_EN
    if (sx >= (1 << (W-1))) sx = sx - (1 << W);
    if (sy >= (1 << (W-1))) sy = sy - (1 << W);
`endif
    return (2*W)'(sx * sy);
  endfunction

  // out_ready: 0 = always high, 1 = random, 2 = held low for 5 cycles of out_valid
  initial begin
    int hv;
    hv = 0;
    forever begin
      @(posedge Clk);
      #1;
      hv = bus.out_valid ? hv + 1 : 0;
      case (or_mode)
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = (hv > 5);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  initial forever begin
    @(negedge Clk);
    if (Rst_n) begin
      chk("no_overlap", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
      if (pend_ir) begin
        chk("in_ready_after_result", {31'd0, bus.in_ready}, 32'd1);
        pend_ir = 0;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          chk("prod", {16'd0, bus.prod}, {16'd0, q[0].p});
          if (!seen) chk("latency", cyc - q[0].acc, W);
          seen = 1;
          if (bus.out_ready) begin
            void'(q.pop_front());
            seen    = 0;
            pend_ir = 1;
          end
        end
      end
    end
  end

  // Called at a negedge; holds operands until accepted, then scrambles them.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int   t;
    exp_t e;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t <= 100) begin
      @(negedge Clk);
      t++;
    end
    if (t > 100) begin
      chk("accept_timeout", 32'(t), 32'd0);
    end else begin
      e.p   = model(x, y);
      e.acc = cyc + 1;
      q.push_back(e);
      @(negedge Clk);
    end
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge Clk);
      t++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    Rst_n         = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_prod", {16'd0, bus.prod}, 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    send(8'd255, 8'd255);
    send(8'd0, 8'd173);
    send(8'd1, 8'd200);
    drain();

    or_mode = 2;
    send(8'd50, 8'd7);
    send(8'd9, 8'd11);
    drain();
    or_mode = 0;
    repeat (2) @(negedge Clk);

    send(8'd200, 8'd100);
    repeat (3) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_prod", {16'd0, bus.prod}, 32'd0);
    q.delete();
    seen    = 0;
    pend_ir = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    send(8'd12, 8'd13);
    drain();

`ifdef MUL_SEQ_SIGNED_EN
    send(8'h80, 8'h80);
    send(8'hFD, 8'd5);
    send(8'd127, 8'h80);
    drain();
`endif

    or_mode = 1;
    for (int i = 0; i < 100; i++) send(W'($urandom), W'($urandom));
    drain();
    or_mode = 0;

    repeat (3) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
